gate_tt_sweep: RTL and testbench

- Self-test sequencer for the team's two-input, seven-output primitive gate array (OR, AND, NOT a, NAND, NOR, XOR, XNOR).
- On `start`, it drives all four input vectors onto the array, waits a programmable settle time, and samples the outputs.
- It assembles a 4-entry truth table per gate and compares each table against the golden tables.
- It reports a per-gate fail mask and an overall pass flag. It sits between the array and the chip-level BIST/status logic.

---
 rtl/gate_tt_pkg.sv | 34 +++
 rtl/gate_tt_check.sv | 15 +
 rtl/gate_tt_sweep.sv | 104 ++++++++++
 tb/tb_gate_tt_sweep.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tt_pkg.sv
// Shared constants for the primitive gate-array self-test: gate indices,
// golden truth tables and the sweep sequencer state encoding.
package gate_tt_pkg;

    localparam int NUM_GATES = 7;

    localparam int GATE_OR   = 0;
    localparam int GATE_AND  = 1;
    localparam int GATE_NOTA = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    localparam int TT_W = 4 * NUM_GATES;

    // Each nibble is one gate's table, bit k holding the output for {a,b} = k.
    localparam logic [TT_W-1:0] GOLDEN_TT =
          (TT_W'(4'b1110) << (4 * GATE_OR))
        | (TT_W'(4'b1000) << (4 * GATE_AND))
        | (TT_W'(4'b0011) << (4 * GATE_NOTA))
        | (TT_W'(4'b0111) << (4 * GATE_NAND))
        | (TT_W'(4'b0001) << (4 * GATE_NOR))
        | (TT_W'(4'b0110) << (4 * GATE_XOR))
        | (TT_W'(4'b1001) << (4 * GATE_XNOR));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

endpackage

// File: rtl/gate_tt_check.sv
// Combinational truth-table comparator: one fail bit per gate whose 4-bit
// captured table differs from the supplied golden table.
module gate_tt_check #(
    parameter int NUM_GATES = 7
) (
    input  logic [4*NUM_GATES-1:0] captured,
    input  logic [4*NUM_GATES-1:0] golden,
    output logic [NUM_GATES-1:0]   fail_mask
);

    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_cmp
        assign fail_mask[gi] = (captured[4*gi +: 4] != golden[4*gi +: 4]);
    end

endmodule

// File: rtl/gate_tt_sweep.sv
// Self-test sequencer: walks {a,b} through 00..11, samples the gate array after
// a settle delay, builds per-gate truth tables and flags mismatches vs golden.
module gate_tt_sweep #(
    parameter int SETTLE_CYC = 2,
    parameter int NUM_GATES  = gate_tt_pkg::NUM_GATES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   gate_a,
    output logic                   gate_b,
    input  logic [NUM_GATES-1:0]   gate_y,
    output logic                   busy,
    output logic                   done,
    output logic [4*NUM_GATES-1:0] tt_out,
    output logic [NUM_GATES-1:0]   fail_mask,
    output logic                   pass
);

    import gate_tt_pkg::*;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e                   state_reg;
    logic [1:0]               k_reg;
    logic [3:0]               cnt_reg;
    logic [4*NUM_GATES-1:0]   tt_next;
    logic [NUM_GATES-1:0]     fail_next;

    // Table as it will look after this cycle's sample is written; the last
    // sample's judgement uses it so results are ready in the CHECK cycle.
    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_cap
        logic [3:0] nib;
        always_comb begin
            nib        = tt_out[4*gi +: 4];
            nib[k_reg] = gate_y[gi];
        end
        assign tt_next[4*gi +: 4] = nib;
    end

    gate_tt_check #(
        .NUM_GATES (NUM_GATES)
    ) u_check (
        .captured  (tt_next),
        .golden    (GOLDEN_TT),
        .fail_mask (fail_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            k_reg     <= 2'd0;
            cnt_reg   <= 4'd0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            tt_out    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= SETTLE;
                        k_reg     <= 2'd0;
                        cnt_reg   <= 4'd0;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == SETTLE_LAST) begin
                        state_reg <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tt_out <= tt_next;
                    if (k_reg != 2'd3) begin
                        k_reg            <= k_reg + 2'd1;
                        {gate_a, gate_b} <= k_reg + 2'd1;
                        cnt_reg          <= 4'd0;
                        state_reg        <= SETTLE;
                    end else begin
                        fail_mask <= fail_next;
                        pass      <= ~|fail_next;
                        done      <= 1'b1;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_sweep.sv
// Bench for gate_tt_sweep: behavioural gate array with injectable faults,
// three sequencer instances (SETTLE_CYC 2, 1, 15) and a done-driven scoreboard.
`timescale 1ns/1ps
module tb_gate_tt_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_v [3];
    logic       ga_v    [3];
    logic       gb_v    [3];
    logic [6:0] y_v     [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       pass_v  [3];
    logic [27:0] tt_v   [3];
    logic [6:0] fm_v    [3];
    int         fault;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          inst;
        logic [27:0] tt;
        logic [6:0]  mask;
        logic        pass;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int          fault;
        logic [27:0] tt;
        logic [6:0]  mask;
        logic        pass;
    } vec_t;
    vec_t vecs[5];

    // Behavioural array: 0 healthy, 1 XOR stuck-0, 2 NOT a follows b,
    // 3 AND stuck-1, 4 every output inverted.
    function automatic logic [6:0] array_eval(input logic a, input logic b, input int f);
        logic [6:0] y;
        y[0] = a | b;
        y[1] = a & b;
        y[2] = ~a;
        y[3] = ~(a & b);
        y[4] = ~(a | b);
        y[5] = a ^ b;
        y[6] = ~(a ^ b);
        if (f == 1) y[5] = 1'b0;
        if (f == 2) y[2] = b;
        if (f == 3) y[1] = 1'b1;
        if (f == 4) y = ~y;
        return y;
    endfunction

    assign y_v[0] = array_eval(ga_v[0], gb_v[0], fault);
    assign y_v[1] = array_eval(ga_v[1], gb_v[1], fault);
    assign y_v[2] = array_eval(ga_v[2], gb_v[2], fault);

    gate_tt_sweep #(.SETTLE_CYC(2), .NUM_GATES(7)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate_a(ga_v[0]), .gate_b(gb_v[0]),
        .gate_y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]), .tt_out(tt_v[0]),
        .fail_mask(fm_v[0]), .pass(pass_v[0]));
    gate_tt_sweep #(.SETTLE_CYC(1), .NUM_GATES(7)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate_a(ga_v[1]), .gate_b(gb_v[1]),
        .gate_y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]), .tt_out(tt_v[1]),
        .fail_mask(fm_v[1]), .pass(pass_v[1]));
    gate_tt_sweep #(.SETTLE_CYC(15), .NUM_GATES(7)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .gate_a(ga_v[2]), .gate_b(gb_v[2]),
        .gate_y(y_v[2]), .busy(busy_v[2]), .done(done_v[2]), .tt_out(tt_v[2]),
        .fail_mask(fm_v[2]), .pass(pass_v[2]));

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every done pops the oldest expectation pushed at start time.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && done_v[i]) begin
                check(sb_q.size() != 0, "sb_unexpected_done", 32'(i), 32'hFFFF_FFFF);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check(e.inst == i, "sb_inst", 32'(i), 32'(e.inst));
                    check(tt_v[i] == e.tt, "sb_tt_out", 32'(tt_v[i]), 32'(e.tt));
                    check(fm_v[i] == e.mask, "sb_fail_mask", 32'(fm_v[i]), 32'(e.mask));
                    check(pass_v[i] == e.pass, "sb_pass", 32'(pass_v[i]), 32'(e.pass));
                    $display("done inst=%0d tt_out=%h fail_mask=%b pass=%b", i, tt_v[i], fm_v[i], pass_v[i]);
                end
            end
        end
    end

    // One start pulse, then walk the sweep checking busy, vector timing and done latency.
    task automatic do_sweep(input int idx, input int sc, input vec_t v, input bit ign);
        exp_t e;
        int   last;
        int   done_cyc;
        int   vec_err;
        int   expv;
        last     = 4 * (sc + 1) + 1;
        done_cyc = -1;
        vec_err  = 0;
        fault    = v.fault;
        e.inst = idx; e.tt = v.tt; e.mask = v.mask; e.pass = v.pass;
        sb_q.push_back(e);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1 start_v[idx] = 1'b0;
        for (int n = 1; n <= last + 10; n++) begin
            @(negedge clk);
            start_v[idx] = ign && (n == 3 || n == 7);
            if (n == 1)
                check(busy_v[idx] && !pass_v[idx], "busy_rise_pass_clear",
                      32'({busy_v[idx], pass_v[idx]}), 32'h2);
            if (n <= last) begin
                expv = (n - 1) / (sc + 1);
                if (expv > 3) expv = 3;
                if ({ga_v[idx], gb_v[idx]} != 2'(expv)) vec_err++;
            end
            if (done_v[idx]) begin
                done_cyc = n;
                break;
            end
        end
        start_v[idx] = 1'b0;
        check(vec_err == 0, "vector_timing", 32'(vec_err), 32'h0);
        check(done_cyc == last, "done_cycle", 32'(done_cyc), 32'(last));
        if (done_cyc < 0) sb_q.delete();
        @(negedge clk);
        check(!busy_v[idx] && !done_v[idx], "post_done_idle",
              32'({busy_v[idx], done_v[idx]}), 32'h0);
        $display("sweep inst=%0d sc=%0d fault=%0d done_cycle=%0d", idx, sc, v.fault, done_cyc);
    endtask

    task automatic drain(input int idx, input int ncyc);
        int ndone;
        ndone = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (done_v[idx]) ndone++;
        end
        check(ndone == 0 && !busy_v[idx], "quiet_after_sweep", 32'({ndone[30:0], busy_v[idx]}), 32'h0);
    endtask

    initial begin
        int d1;
        int d2;
        vecs[0] = '{0, 28'h961738E, 7'b0000000, 1'b1};
        vecs[1] = '{1, 28'h901738E, 7'b0100000, 1'b0};
        vecs[2] = '{2, 28'h9617A8E, 7'b0000100, 1'b0};
        vecs[3] = '{3, 28'h96173FE, 7'b0000010, 1'b0};
        vecs[4] = '{4, 28'h69E8C71, 7'b1111111, 1'b0};

        fault = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check({ga_v[0], gb_v[0], busy_v[0], done_v[0], pass_v[0], fm_v[0], tt_v[0]} == '0,
                  "reset_idle_zero", {busy_v[0], done_v[0], pass_v[0], fm_v[0], tt_v[0][22:0]}, 32'h0);
        end

        for (int i = 0; i < 5; i++) begin
            do_sweep(0, 2, vecs[i], 1'b0);
            drain(0, 3);
        end

        // start pulses at cycles 3 and 7 must neither queue nor restart
        do_sweep(0, 2, vecs[0], 1'b1);
        drain(0, 16);

        // start held high: back-to-back sweeps, done 14 cycles apart
        fault = 0;
        sb_q.push_back('{0, 28'h961738E, 7'b0000000, 1'b1});
        sb_q.push_back('{0, 28'h961738E, 7'b0000000, 1'b1});
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done_v[0]) begin
                if (d1 < 0) d1 = n;
                else begin
                    d2 = n;
                    start_v[0] = 1'b0;
                    break;
                end
            end
        end
        start_v[0] = 1'b0;
        check(d1 == 13, "held_first_done", 32'(d1), 32'd13);
        check(d2 - d1 == 14, "held_done_spacing", 32'(d2 - d1), 32'd14);
        $display("held start: first done=%0d second done=%0d", d1, d2);
        if (d2 < 0) sb_q.delete();
        drain(0, 16);

        // reset during cycle 6 aborts the sweep with no surviving results
        fault = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        check(busy_v[0], "abort_busy_before", 32'(busy_v[0]), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check({ga_v[0], gb_v[0], busy_v[0], done_v[0], pass_v[0], fm_v[0], tt_v[0]} == '0,
              "abort_cleared", {busy_v[0], pass_v[0], fm_v[0], tt_v[0][22:0]}, 32'h0);
        rst_n = 1'b1;
        drain(0, 20);
        $display("reset abort: busy=%b tt_out=%h", busy_v[0], tt_v[0]);
        do_sweep(0, 2, vecs[0], 1'b0);

        do_sweep(1, 1, vecs[0], 1'b0);
        drain(1, 3);
        do_sweep(2, 15, vecs[0], 1'b0);
        drain(2, 3);
        do_sweep(1, 1, vecs[1], 1'b0);
        do_sweep(2, 15, vecs[2], 1'b0);

        check(sb_q.size() == 0, "sb_all_consumed", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
